// File: rtl/parking_pkg.sv
// Shared constants for the car-park barrier controller: state encodings,
// lane direction codes and the slot-count width.
package parking_pkg;

  localparam int SLOT_W = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_OPEN  = 2'd1;
  localparam logic [1:0] ST_CLOSE = 2'd2;

  localparam logic DIR_ENTRY = 1'b0;
  localparam logic DIR_EXIT  = 1'b1;

endpackage

// File: rtl/parking_gate_ctrl_if.sv
// Lane request / sensor inputs and barrier / status outputs of the
// shared car-park gate controller.
interface parking_gate_ctrl_if;
  import parking_pkg::*;

  logic              enter_req;
  logic              exit_req;
  logic              car_passed;
  logic              gate_open;
  logic              gate_dir;
  logic              car_enter;
  logic              car_leave;
  logic              timeout;
  logic              full;
  logic [SLOT_W-1:0] free_slots;
  logic              busy;

  modport master (
    output enter_req, exit_req, car_passed,
    input  gate_open, gate_dir, car_enter, car_leave, timeout, full, free_slots, busy
  );

  modport slave (
    input  enter_req, exit_req, car_passed,
    output gate_open, gate_dir, car_enter, car_leave, timeout, full, free_slots, busy
  );

endinterface

// File: rtl/parking_gate_ctrl_gate_timer.sv
// Loadable down-counter shared by the OPEN timeout and the CLOSE hold;
// saturates at zero and flags done while at zero.
module gate_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic [W-1:0] value,
  output logic         done
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value <= '0;
    end else if (load) begin
      value <= load_value;
    end else if (value != '0) begin
      value <= value - 1'b1;
    end
  end

  assign done = (value == '0);

endmodule

// File: rtl/parking_gate_ctrl.sv
// Single-barrier entry/exit arbiter with occupancy tracking: opens the gate
// for an eligible lane, waits for the sensor or a timeout, then holds closed.
module parking_gate_ctrl
  import parking_pkg::*;
#(
  parameter int CAPACITY     = 8,
  parameter int OPEN_TIMEOUT = 16,
  parameter int CLOSE_CYCLES = 4
) (
  input logic                clk,
  input logic                reset,
  parking_gate_ctrl_if.slave gate
);

  localparam int TMAX = (OPEN_TIMEOUT > CLOSE_CYCLES) ? OPEN_TIMEOUT : CLOSE_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [TW-1:0]     OPEN_LOAD  = TW'(OPEN_TIMEOUT - 1);
  localparam logic [TW-1:0]     CLOSE_LOAD = TW'(CLOSE_CYCLES - 1);
  localparam logic [SLOT_W-1:0] CAP        = SLOT_W'(CAPACITY);

  logic [1:0]        state;
  logic [SLOT_W-1:0] occ;
  logic              last_dir;
  logic              open_q, dir_q, enter_q, leave_q, timeout_q;

  logic              enter_ok, exit_ok, pick_dir;
  logic              tmr_load, tmr_done;
  logic [TW-1:0]     tmr_load_value, tmr_value;

  assign enter_ok = gate.enter_req && (occ < CAP);
  assign exit_ok  = gate.exit_req && (occ != '0);
  // On a tie the lane not served last wins; otherwise the lone eligible lane.
  assign pick_dir = (enter_ok && exit_ok) ? ~last_dir : exit_ok;

  always_comb begin
    tmr_load       = 1'b0;
    tmr_load_value = OPEN_LOAD;
    case (state)
      ST_IDLE: tmr_load = enter_ok || exit_ok;
      ST_OPEN: begin
        if (gate.car_passed || tmr_done) begin
          tmr_load       = 1'b1;
          tmr_load_value = CLOSE_LOAD;
        end
      end
      default: ;
    endcase
  end

  gate_timer #(.W(TW)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (tmr_load),
    .load_value (tmr_load_value),
    .value      (tmr_value),
    .done       (tmr_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      occ       <= '0;
      last_dir  <= DIR_EXIT;
      open_q    <= 1'b0;
      dir_q     <= DIR_ENTRY;
      enter_q   <= 1'b0;
      leave_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      enter_q   <= 1'b0;
      leave_q   <= 1'b0;
      timeout_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (enter_ok || exit_ok) begin
            state  <= ST_OPEN;
            open_q <= 1'b1;
            dir_q  <= pick_dir;
          end
        end
        ST_OPEN: begin
          if (gate.car_passed) begin
            state    <= ST_CLOSE;
            open_q   <= 1'b0;
            last_dir <= dir_q;
            if (dir_q == DIR_ENTRY) begin
              enter_q <= 1'b1;
              occ     <= occ + 1'b1;
            end else begin
              leave_q <= 1'b1;
              occ     <= occ - 1'b1;
            end
          end else if (tmr_done) begin
            state     <= ST_CLOSE;
            open_q    <= 1'b0;
            last_dir  <= dir_q;
            timeout_q <= 1'b1;
          end
        end
        ST_CLOSE: begin
          if (tmr_done) state <= ST_IDLE;
        end
        default: begin
          state  <= ST_IDLE;
          open_q <= 1'b0;
        end
      endcase
    end
  end

  assign gate.gate_open  = open_q;
  assign gate.gate_dir   = dir_q;
  assign gate.car_enter  = enter_q;
  assign gate.car_leave  = leave_q;
  assign gate.timeout    = timeout_q;
  assign gate.full       = (occ == CAP);
  assign gate.free_slots = CAP - occ;
  assign gate.busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Self-checking bench for parking_gate_ctrl: directed scenarios plus random
// service sequences checked against a transaction-level occupancy model.
module tb_parking_gate_ctrl;
  import parking_pkg::*;

  localparam int CAP = 8;
  localparam int T   = 16;
  localparam int C   = 4;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  int   m_occ;
  bit   m_last;

  always #5 clk = ~clk;

  parking_gate_ctrl_if bus ();

  parking_gate_ctrl #(
    .CAPACITY     (CAP),
    .OPEN_TIMEOUT (T),
    .CLOSE_CYCLES (C)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .gate  (bus)
  );

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // One service attempt from IDLE: request lanes e/x, car clears after d open
  // cycles (d >= T means never), optional spurious sensor in CLOSE and IDLE.
  task automatic do_service(input bit e, input bit x, input int d, input bit spur);
    bit e_ok, x_ok, dir, passed;
    int n_open, n_close, exp_open;
    e_ok = e && (m_occ < CAP);
    x_ok = x && (m_occ > 0);
    @(negedge clk);
    bus.enter_req  = e;
    bus.exit_req   = x;
    bus.car_passed = 1'b0;
    if (!(e_ok || x_ok)) begin
      repeat (3) begin
        @(negedge clk);
        checks++;
        if (bus.gate_open !== 1'b0 || bus.busy !== 1'b0) begin
          errors++;
          $display("FAIL no_service: gate_open=%b busy=%b required 0 0 (e=%b x=%b occ=%0d)",
                   bus.gate_open, bus.busy, e, x, m_occ);
        end
      end
      bus.enter_req = 1'b0;
      bus.exit_req  = 1'b0;
    end else begin
      dir = (e_ok && x_ok) ? ~m_last : x_ok;
      @(negedge clk);
      bus.enter_req = 1'b0;
      bus.exit_req  = 1'b0;
      checks++;
      if (bus.gate_open !== 1'b1 || bus.gate_dir !== dir) begin
        errors++;
        $display("FAIL open_latency: gate_open=%b gate_dir=%b required 1 %b",
                 bus.gate_open, bus.gate_dir, dir);
      end
      passed   = (d < T);
      exp_open = passed ? d + 1 : T;
      n_open   = 0;
      while (bus.gate_open === 1'b1 && n_open < T + 5) begin
        n_open++;
        bus.car_passed = (n_open == d + 1);
        @(negedge clk);
      end
      bus.car_passed = spur;
      m_last = dir;
      if (passed) m_occ = dir ? m_occ - 1 : m_occ + 1;
      checks++;
      if (n_open != exp_open) begin
        errors++;
        $display("FAIL open_duration: got %0d cycles required %0d", n_open, exp_open);
      end
      checks++;
      if (bus.car_enter !== (passed && !dir) || bus.car_leave !== (passed && dir) ||
          bus.timeout !== !passed) begin
        errors++;
        $display("FAIL pulses: enter=%b leave=%b timeout=%b required %b %b %b",
                 bus.car_enter, bus.car_leave, bus.timeout, passed && !dir, passed && dir, !passed);
      end
      checks++;
      if (bus.free_slots !== 4'(CAP - m_occ) || bus.full !== (m_occ == CAP)) begin
        errors++;
        $display("FAIL occupancy: free_slots=%0d full=%b required %0d %b",
                 bus.free_slots, bus.full, CAP - m_occ, m_occ == CAP);
      end
      n_close = 0;
      while (bus.busy === 1'b1 && n_close < C + 5) begin
        n_close++;
        @(negedge clk);
        checks++;
        if (bus.car_enter !== 1'b0 || bus.car_leave !== 1'b0 || bus.timeout !== 1'b0 ||
            bus.gate_open !== 1'b0) begin
          errors++;
          $display("FAIL close_quiet: enter=%b leave=%b timeout=%b gate_open=%b required all 0",
                   bus.car_enter, bus.car_leave, bus.timeout, bus.gate_open);
        end
      end
      checks++;
      if (n_close != C) begin
        errors++;
        $display("FAIL close_hold: got %0d cycles required %0d", n_close, C);
      end
      if (spur) begin
        @(negedge clk);
        checks++;
        if (bus.car_enter !== 1'b0 || bus.car_leave !== 1'b0 ||
            bus.free_slots !== 4'(CAP - m_occ)) begin
          errors++;
          $display("FAIL spurious: enter=%b leave=%b free_slots=%0d required 0 0 %0d",
                   bus.car_enter, bus.car_leave, bus.free_slots, CAP - m_occ);
        end
      end
      bus.car_passed = 1'b0;
    end
  endtask

  task automatic test_reset;
    bus.enter_req  = 1'b0;
    bus.exit_req   = 1'b0;
    bus.car_passed = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.gate_open !== 1'b0 || bus.gate_dir !== 1'b0 || bus.car_enter !== 1'b0 ||
        bus.car_leave !== 1'b0 || bus.timeout !== 1'b0 || bus.full !== 1'b0 ||
        bus.free_slots !== 4'(CAP) || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: open=%b dir=%b enter=%b leave=%b to=%b full=%b free=%0d busy=%b required 0 0 0 0 0 0 %0d 0",
               bus.gate_open, bus.gate_dir, bus.car_enter, bus.car_leave, bus.timeout,
               bus.full, bus.free_slots, bus.busy, CAP);
    end
    reset  = 1'b0;
    m_occ  = 0;
    m_last = 1'b1;
  endtask

  task automatic test_empty_exit;
    do_service(1'b0, 1'b1, 0, 1'b0);
  endtask

  task automatic test_single_entry;
    do_service(1'b1, 1'b0, 1, 1'b0);
    checks++;
    if (bus.free_slots !== 4'd7) begin
      errors++;
      $display("FAIL single_entry_slots: free_slots=%0d required 7", bus.free_slots);
    end
  endtask

  task automatic test_tie;
    do_service(1'b1, 1'b0, 0, 1'b0);
    do_service(1'b1, 1'b0, 2, 1'b0);
    do_service(1'b1, 1'b0, 0, 1'b0);
    do_service(1'b0, 1'b1, 0, 1'b0);
    for (int i = 0; i < 4; i++) do_service(1'b1, 1'b1, 1, 1'b0);
  endtask

  task automatic test_timeout;
    do_service(1'b1, 1'b0, T + 3, 1'b0);
    do_service(1'b0, 1'b1, T, 1'b0);
  endtask

  task automatic test_spurious;
    do_service(1'b1, 1'b0, 3, 1'b1);
    do_service(1'b0, 1'b1, 0, 1'b1);
  endtask

  task automatic test_full;
    while (m_occ < CAP) do_service(1'b1, 1'b0, 0, 1'b0);
    checks++;
    if (bus.full !== 1'b1 || bus.free_slots !== 4'd0) begin
      errors++;
      $display("FAIL full_flag: full=%b free_slots=%0d required 1 0", bus.full, bus.free_slots);
    end
    do_service(1'b1, 1'b0, 0, 1'b0);
    do_service(1'b1, 1'b1, 0, 1'b0);
  endtask

  task automatic test_random;
    for (int i = 0; i < 60; i++)
      do_service(1'($urandom), 1'($urandom), int'($urandom_range(0, T + 2)), 1'($urandom));
  endtask

  task automatic test_reset_mid_open;
    if (m_occ == CAP) do_service(1'b0, 1'b1, 0, 1'b0);
    if (m_occ == 0) do_service(1'b1, 1'b0, 0, 1'b0);
    @(negedge clk);
    bus.enter_req = 1'b1;
    @(negedge clk);
    bus.enter_req = 1'b0;
    checks++;
    if (bus.gate_open !== 1'b1) begin
      errors++;
      $display("FAIL mid_open_setup: gate_open=%b required 1", bus.gate_open);
    end
    @(negedge clk);
    bus.car_passed = 1'b1;
    #2 reset = 1'b1;
    #1;
    checks++;
    if (bus.gate_open !== 1'b0 || bus.free_slots !== 4'(CAP) || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: gate_open=%b free_slots=%0d busy=%b required 0 %0d 0",
               bus.gate_open, bus.free_slots, bus.busy, CAP);
    end
    @(negedge clk);
    reset          = 1'b0;
    bus.car_passed = 1'b0;
    m_occ          = 0;
    m_last         = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (bus.car_enter !== 1'b0 || bus.car_leave !== 1'b0 || bus.gate_open !== 1'b0) begin
        errors++;
        $display("FAIL post_reset_quiet: enter=%b leave=%b gate_open=%b required 0 0 0",
                 bus.car_enter, bus.car_leave, bus.gate_open);
      end
    end
    do_service(1'b1, 1'b1, 0, 1'b0);
  endtask

  initial begin
    test_reset;
    test_empty_exit;
    test_single_entry;
    test_tie;
    test_timeout;
    test_spurious;
    test_full;
    test_random;
    test_reset_mid_open;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
